// File: rtl/bit_twiddler_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_twiddler_seq
// Description : Sequential bit twiddler. Performs bit reverse, two's-complement
//               negate, rotate right or rotate left on a W-bit word under a
//               start/busy/done handshake. Rotation advances one bit position
//               per clock so the datapath stays small for wide W.
// Ports       : clk   - rising-edge clock
//               rst   - asynchronous active-high reset
//               start - request, sampled only when idle
//               op    - 00 reverse, 01 negate, 10 rotate right, 11 rotate left
//               x     - operand
//               sh    - rotate amount (ignored for op 00/01)
//               busy  - high while an operation is in progress
//               done  - one-cycle completion pulse
//               q     - result, holds last completed value
//               ovf   - negate overflow flag, valid with q
// Revision    : 1.0 - initial release
// ============================================================================
module bit_twiddler_seq #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [W-1:0]  x,
    input  logic [SW-1:0] sh,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  q,
    output logic          ovf
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0]    c_OP_REV  = 2'b00;
    localparam logic [1:0]    c_OP_NEG  = 2'b01;
    localparam logic [1:0]    c_OP_ROR  = 2'b10;
    localparam logic [W-1:0]  c_ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  c_MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [SW-1:0] c_ONE_SW  = {{(SW-1){1'b0}}, 1'b1};

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_work,  w_work_nxt;
    logic [SW-1:0] r_cnt,   w_cnt_nxt;
    logic [1:0]    r_op,    w_op_nxt;
    logic [W-1:0]  r_q,     w_q_nxt;
    logic          r_done,  w_done_nxt;
    logic          r_ovf,   w_ovf_nxt;

    logic [W-1:0]  w_rev;
    logic [W-1:0]  w_result;

    // Bit-reversed view of the working register
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < W; i++) begin
            w_rev[i] = r_work[W-1-i];
        end
    end

    // Final result selection; rotates are already complete in r_work by the
    // time the count reaches zero.
    always_comb begin
        case (r_op)
            c_OP_REV: w_result = w_rev;
            c_OP_NEG: w_result = ~r_work + c_ONE_W;
            default:  w_result = r_work;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_q_nxt     = r_q;
        w_ovf_nxt   = r_ovf;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_work_nxt  = x;
                    w_op_nxt    = op;
                    // Only rotates consume cycles; reverse/negate finish next edge
                    w_cnt_nxt   = op[1] ? sh : '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt != '0) begin
                    if (r_op == c_OP_ROR) begin
                        w_work_nxt = {r_work[0], r_work[W-1:1]};
                    end else begin
                        w_work_nxt = {r_work[W-2:0], r_work[W-1]};
                    end
                    w_cnt_nxt = r_cnt - c_ONE_SW;
                end else begin
                    w_q_nxt     = w_result;
                    w_ovf_nxt   = (r_op == c_OP_NEG) && (r_work == c_MOST_NEG);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign q    = r_q;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
